// File: rtl/audio_pkg.sv
// audio_pkg: shared types and default constants for the beep tone generator.
package audio_pkg;

  // Envelope state machine encoding
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } beep_state_t;

  // Signed audio sample word handed to the codec
  typedef logic signed [15:0] sample_t;

  // Default tone: about 441 Hz at 44.1 kHz, moderate loudness, short ramps
  localparam int BEEP_HALF_PERIOD = 50;
  localparam int BEEP_AMP_MAX     = 8000;
  localparam int BEEP_STEP        = 250;

endpackage : audio_pkg

// File: rtl/beep_envelope.sv
// beep_envelope: linear attack/sustain/release amplitude envelope.
// Advances only on sample_req. amp_next/idle_next expose the value being
// computed for the current sample so the top level can register the signed
// sample in the same cycle; amp/busy are the registered envelope state.
module beep_envelope
  import audio_pkg::*;
#(
  parameter int AMP_MAX = BEEP_AMP_MAX,
  parameter int STEP    = BEEP_STEP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_req,
  input  logic        enable,
  output logic [15:0] amp_next,
  output logic        idle_next,
  output logic [15:0] amp,
  output logic        busy
);

  beep_state_t state_q, state_d, state_nx;
  logic [15:0] amp_q, amp_d;
  logic        busy_q, busy_d;

  logic [31:0] att_sum;
  logic        att_full;
  logic [15:0] att_amp;
  logic [15:0] rel_amp;

  // Candidate amplitudes for a ramp-up or ramp-down step from the current amp
  always_comb begin
    att_sum  = 32'(amp_q) + 32'(STEP);
    att_full = (att_sum >= 32'(AMP_MAX));
    if (att_full) begin
      att_amp = 16'(AMP_MAX);
    end else begin
      att_amp = att_sum[15:0];
    end
    if (32'(amp_q) <= 32'(STEP)) begin
      rel_amp = 16'd0;
    end else begin
      rel_amp = amp_q - 16'(STEP);
    end
  end

  // Next state and amplitude for this sample; enable is acted on immediately
  always_comb begin
    state_nx = state_q;
    amp_next = amp_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          amp_next = att_amp;
          state_nx = att_full ? SUSTAIN : ATTACK;
        end else begin
          amp_next = 16'd0;
          state_nx = IDLE;
        end
      end
      ATTACK, RELEASE: begin
        if (enable) begin
          amp_next = att_amp;
          state_nx = att_full ? SUSTAIN : ATTACK;
        end else begin
          amp_next = rel_amp;
          state_nx = (rel_amp == 16'd0) ? IDLE : RELEASE;
        end
      end
      SUSTAIN: begin
        if (enable) begin
          amp_next = amp_q;
          state_nx = SUSTAIN;
        end else begin
          amp_next = rel_amp;
          state_nx = (rel_amp == 16'd0) ? IDLE : RELEASE;
        end
      end
      default: begin
        amp_next = 16'd0;
        state_nx = IDLE;
      end
    endcase
    idle_next = (state_nx == IDLE);
  end

  // Commit the envelope step only on a sample request; hold otherwise
  always_comb begin
    state_d = state_q;
    amp_d   = amp_q;
    busy_d  = busy_q;
    if (sample_req) begin
      state_d = state_nx;
      amp_d   = amp_next;
      busy_d  = (state_nx != IDLE);
    end else begin
      state_d = state_q;
      amp_d   = amp_q;
      busy_d  = busy_q;
    end
  end

  // Envelope state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      amp_q   <= 16'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      amp_q   <= amp_d;
      busy_q  <= busy_d;
    end
  end

  assign amp  = amp_q;
  assign busy = busy_q;

endmodule : beep_envelope

// File: rtl/audio_beep_gen.sv
// audio_beep_gen: square-wave beep with click-free envelope for audio_codec.
// Optional feature macro AUDIO_BEEP_VOL_EN adds a 4-bit vol port and a
// registered volume scaling stage (audio_output one cycle later than busy).
module audio_beep_gen
  import audio_pkg::*;
#(
  parameter int HALF_PERIOD = BEEP_HALF_PERIOD,
  parameter int AMP_MAX     = BEEP_AMP_MAX,
  parameter int STEP        = BEEP_STEP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_req,
  input  logic        enable,
`ifdef AUDIO_BEEP_VOL_EN
  input  logic [3:0]  vol,
`endif
  output logic [15:0] audio_output,
  output logic        busy
);

  localparam int PH_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);

  logic [15:0] amp_next;
  logic        idle_next;
  logic [15:0] env_amp;
  logic        env_busy;

  beep_envelope #(
    .AMP_MAX (AMP_MAX),
    .STEP    (STEP)
  ) u_env (
    .clk        (clk),
    .reset      (reset),
    .sample_req (sample_req),
    .enable     (enable),
    .amp_next   (amp_next),
    .idle_next  (idle_next),
    .amp        (env_amp),
    .busy       (env_busy)
  );

  logic [PH_W-1:0]   phase_q, phase_d;
  logic              pol_q, pol_d;     // 1 = negative half cycle
  sample_t           sample_q, sample_d;
  logic signed [16:0] mag_s;
  logic signed [16:0] signed_s;

  // Sign the new amplitude and step the phase/polarity counter per sample
  always_comb begin
    phase_d  = phase_q;
    pol_d    = pol_q;
    sample_d = sample_q;
    mag_s    = signed'({1'b0, amp_next});
    if (pol_q) begin
      signed_s = -mag_s;
    end else begin
      signed_s = mag_s;
    end
    if (sample_req) begin
      if (idle_next) begin
        phase_d  = '0;
        pol_d    = 1'b0;
        sample_d = 16'sd0;
      end else begin
        sample_d = signed_s[15:0];
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          pol_d   = ~pol_q;
        end else begin
          phase_d = phase_q + PH_W'(1);
          pol_d   = pol_q;
        end
      end
    end else begin
      phase_d  = phase_q;
      pol_d    = pol_q;
      sample_d = sample_q;
    end
  end

  // Phase, polarity and first-stage sample registers
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q  <= '0;
      pol_q    <= 1'b0;
      sample_q <= 16'sd0;
    end else begin
      phase_q  <= phase_d;
      pol_q    <= pol_d;
      sample_q <= sample_d;
    end
  end

`ifdef AUDIO_BEEP_VOL_EN
  logic               vld_q, vld_d;
  sample_t            scaled_q, scaled_d;
  logic [4:0]         gain_u;
  logic signed [20:0] gain_s;
  logic signed [20:0] samp_ext_s;
  logic signed [20:0] prod_s;
  logic signed [20:0] shr_s;

  // Scale the registered sample by (vol+1)/16, updating one cycle after it
  always_comb begin
    gain_u     = {1'b0, vol} + 5'd1;
    gain_s     = signed'({16'd0, gain_u});
    samp_ext_s = {{5{sample_q[15]}}, sample_q};
    prod_s     = samp_ext_s * gain_s;
    shr_s      = prod_s >>> 4;
    vld_d      = sample_req;
    if (vld_q) begin
      scaled_d = shr_s[15:0];
    end else begin
      scaled_d = scaled_q;
    end
  end

  // Volume stage registers
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q    <= 1'b0;
      scaled_q <= 16'sd0;
    end else begin
      vld_q    <= vld_d;
      scaled_q <= scaled_d;
    end
  end

  assign audio_output = scaled_q;
`else
  assign audio_output = sample_q;
`endif

  assign busy = env_busy;

endmodule : audio_beep_gen
